// File: rtl/shift_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_pkg                                                                |
// | Shared types and constants for the shift-register load controller.      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package shift_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  // Width of the downstream parallel-load shift register
  localparam int SHIFT_W = 3;

  // Width of the completed-frame counter
  localparam int FRAME_CNT_W = 8;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shift_load_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_load_fifo                                                          |
// | Small synchronous FIFO buffering words ahead of the load/shift FSM.     |
// | Pointers wrap naturally; the occupancy count is one bit wider.          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module shift_load_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;

  // Storage array: written on push only, contents need no reset
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == C_FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule : shift_load_fifo
`default_nettype wire

// File: rtl/shift_load_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_load_ctrl                                                          |
// | Feeds a parallel-load shift register: one LOAD cycle per buffered word  |
// | followed by WIDTH SHIFT cycles, with frame busy/done status.            |
// | Optional macro SHIFT_LOAD_CTRL_CNT_EN adds the 8-bit frame_cnt output.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module shift_load_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_W,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   load,
  output logic [WIDTH-1:0]       load_data,
  output logic                   busy,
  output logic                   done
`ifdef SHIFT_LOAD_CTRL_CNT_EN
  ,output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(WIDTH - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           shift_cnt_q, shift_cnt_d;
  logic                    fifo_push, fifo_pop;
  logic                    fifo_full, fifo_empty;
  logic [WIDTH-1:0]        fifo_head;
  logic [$clog2(DEPTH):0]  fifo_count;

  // in_ready looks only at the registered occupancy, never at a same-cycle pop
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;

  shift_load_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (in_data),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // State and shift-counter registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      shift_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
    end
  end

  // Next-state logic; the word is popped on the edge that leaves LOAD
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        // LOAD is only entered with a non-empty FIFO; the count guard
        // keeps the pointers sane if that ever stops holding.
        fifo_pop    = (fifo_count != '0);
        shift_cnt_d = C_CNT_LAST;
        state_d     = SHIFT;
      end
      SHIFT: begin
        if (shift_cnt_q == '0) begin
          state_d = fifo_empty ? IDLE : LOAD;
        end else begin
          shift_cnt_d = shift_cnt_q - CW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        shift_cnt_d = '0;
      end
    endcase
  end

  assign load      = (state_q == LOAD);
  assign load_data = (state_q == LOAD) ? fifo_head : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == SHIFT) && (shift_cnt_q == '0);

`ifdef SHIFT_LOAD_CTRL_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  // Completed-frame counter, wraps naturally at 2^FRAME_CNT_W
  always_ff @(posedge clk) begin
    if (!rstn) begin
      frame_cnt_q <= '0;
    end else if (done) begin
      frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule : shift_load_ctrl
`default_nettype wire
